// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared bus command, tag owner and owner-table entry types
package mem_bus_arbiter_pkg;
  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_cmd_e;

  typedef enum logic {
    OWN_D = 1'b0,
    OWN_I = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } tag_entry_t;
endpackage

// File: rtl/mem_tag_table.sv
// mem_tag_table: per-tag owner table with retire-then-write ordering, popcount and orphan flag
module mem_tag_table
  import mem_bus_arbiter_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [TAG_W-1:0] wr_tag,
  input  owner_e           wr_owner,
  input  logic [TAG_W-1:0] rt_tag,
  output logic             rt_hit,
  output owner_e           rt_owner,
  output logic [TAG_W-1:0] outstanding,
  output logic             orphan_err
);
  localparam int DEPTH = 2 ** TAG_W;
  tag_entry_t [DEPTH-1:0] tbl, nxt;
  logic [TAG_W-1:0] cnt;
  logic rt_miss;
  assign rt_hit   = !reset && rt_tag != '0 && tbl[rt_tag].valid;
  assign rt_miss  = rt_tag != '0 && !tbl[rt_tag].valid;
  assign rt_owner = tbl[rt_tag].owner;
  // Next table: retire first so a same-cycle accept of the same tag overwrites it
  always_comb begin
    nxt = tbl;
    cnt = '0;
    if (rt_hit) nxt[rt_tag].valid = 1'b0;
    if (wr_en && wr_tag != '0) nxt[wr_tag] = '{valid: 1'b1, owner: wr_owner};
    for (int k = 1; k < DEPTH; k++) cnt = cnt + TAG_W'(nxt[k].valid);
  end
  // Table, in-flight count and sticky orphan flag
  always_ff @(posedge clock) begin
    if (reset) begin
      tbl         <= '0;
      outstanding <= '0;
      orphan_err  <= 1'b0;
    end else begin
      tbl         <= nxt;
      outstanding <= cnt;
      orphan_err  <= orphan_err | rt_miss;
    end
  end
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: dcache/icache arbiter for one tagged memory port (MEM_ARB_STATS_EN adds grant counters)
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int TAG_W        = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       Dproc2mem_command,
  input  logic [XLEN-1:0]  Dproc2mem_addr,
  input  logic [63:0]      Dproc2mem_data,
  input  logic [1:0]       Iproc2mem_command,
  input  logic [XLEN-1:0]  Iproc2mem_addr,
  input  logic [TAG_W-1:0] mem2proc_response,
  input  logic [63:0]      mem2proc_data,
  input  logic [TAG_W-1:0] mem2proc_tag,
  output logic [1:0]       proc2mem_command,
  output logic [XLEN-1:0]  proc2mem_addr,
  output logic [63:0]      proc2mem_data,
  output logic             d_request,
  output logic [TAG_W-1:0] Dmem2proc_response,
  output logic [TAG_W-1:0] Imem2proc_response,
  output logic [TAG_W-1:0] Dmem2proc_tag,
  output logic [TAG_W-1:0] Imem2proc_tag,
  output logic [63:0]      mem2proc_data_out,
  output logic [TAG_W-1:0] outstanding,
  output logic             orphan_err
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]      d_grant_cnt,
  output logic [31:0]      i_grant_cnt,
  output logic [31:0]      rejected_cnt
`endif
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_cnt;
  logic d_act, i_act, d_grant, i_grant, accepted, wr_en, rt_hit;
  owner_e rt_owner;
  assign d_act    = Dproc2mem_command != BUS_NONE;
  assign i_act    = Iproc2mem_command != BUS_NONE;
  assign i_grant  = !reset && i_act && (!d_act || starve_cnt == SW'(STARVE_LIMIT));
  assign d_grant  = !reset && d_act && !i_grant;
  assign accepted = mem2proc_response != '0;
  assign wr_en    = accepted && ((d_grant && Dproc2mem_command == BUS_LOAD) ||
                                 (i_grant && Iproc2mem_command == BUS_LOAD));
  // Forward the granted request and route accept/return tags to their owners
  always_comb begin
    proc2mem_command   = d_grant ? Dproc2mem_command : i_grant ? Iproc2mem_command : BUS_NONE;
    proc2mem_addr      = d_grant ? Dproc2mem_addr : i_grant ? Iproc2mem_addr : '0;
    proc2mem_data      = d_grant && Dproc2mem_command == BUS_STORE ? Dproc2mem_data : '0;
    d_request          = d_grant;
    Dmem2proc_response = d_grant ? mem2proc_response : '0;
    Imem2proc_response = i_grant ? mem2proc_response : '0;
    Dmem2proc_tag      = rt_hit && rt_owner == OWN_D ? mem2proc_tag : '0;
    Imem2proc_tag      = rt_hit && rt_owner == OWN_I ? mem2proc_tag : '0;
    mem2proc_data_out  = mem2proc_data;
  end
  // Count consecutive cycles the icache wants the bus but loses it
  always_ff @(posedge clock) begin
    if (reset) starve_cnt <= '0;
    else starve_cnt <= i_act && !i_grant ?
                       (starve_cnt == SW'(STARVE_LIMIT) ? starve_cnt : starve_cnt + 1'b1) : '0;
  end
  mem_tag_table #(.TAG_W(TAG_W)) u_table (
    .clock       (clock),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_tag      (mem2proc_response),
    .wr_owner    (d_grant ? OWN_D : OWN_I),
    .rt_tag      (mem2proc_tag),
    .rt_hit      (rt_hit),
    .rt_owner    (rt_owner),
    .outstanding (outstanding),
    .orphan_err  (orphan_err)
  );
`ifdef MEM_ARB_STATS_EN
  // Accepted-grant and rejected-command counters, wrapping modulo 2^32
  always_ff @(posedge clock) begin
    if (reset) begin
      d_grant_cnt  <= '0;
      i_grant_cnt  <= '0;
      rejected_cnt <= '0;
    end else begin
      d_grant_cnt  <= d_grant_cnt + 32'(d_grant && accepted);
      i_grant_cnt  <= i_grant_cnt + 32'(i_grant && accepted);
      rejected_cnt <= rejected_cnt + 32'((d_grant || i_grant) && !accepted);
    end
  end
`endif
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: scoreboard bench driving hand-computed directed vectors
module tb_mem_bus_arbiter;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  Dproc2mem_command = 2'd0, Iproc2mem_command = 2'd0;
  logic [31:0] Dproc2mem_addr = '0, Iproc2mem_addr = '0;
  logic [63:0] Dproc2mem_data = '0, mem2proc_data = '0;
  logic [3:0]  mem2proc_response = '0, mem2proc_tag = '0;
  logic [1:0]  proc2mem_command;
  logic [31:0] proc2mem_addr;
  logic [63:0] proc2mem_data, mem2proc_data_out;
  logic        d_request, orphan_err;
  logic [3:0]  Dmem2proc_response, Imem2proc_response, Dmem2proc_tag, Imem2proc_tag, outstanding;

  typedef struct packed {
    logic [1:0]  cmd;
    logic [31:0] addr;
    logic [63:0] data;
    logic [63:0] dout;
    logic        dreq;
    logic [3:0]  dresp;
    logic [3:0]  iresp;
    logic [3:0]  dtag;
    logic [3:0]  itag;
    logic [3:0]  outst;
    logic        orph;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int vec_no = 0;

  localparam logic [1:0] N = 2'd0, L = 2'd1, S = 2'd2;
  localparam logic [63:0] DD = 64'h1111_2222_3333_4444;

  mem_bus_arbiter dut (
    .clock(clock), .reset(reset),
    .Dproc2mem_command(Dproc2mem_command), .Dproc2mem_addr(Dproc2mem_addr), .Dproc2mem_data(Dproc2mem_data),
    .Iproc2mem_command(Iproc2mem_command), .Iproc2mem_addr(Iproc2mem_addr),
    .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data), .mem2proc_tag(mem2proc_tag),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr), .proc2mem_data(proc2mem_data),
    .d_request(d_request), .Dmem2proc_response(Dmem2proc_response), .Imem2proc_response(Imem2proc_response),
    .Dmem2proc_tag(Dmem2proc_tag), .Imem2proc_tag(Imem2proc_tag), .mem2proc_data_out(mem2proc_data_out),
    .outstanding(outstanding), .orphan_err(orphan_err)
  );

  always #5 clock = ~clock;

  task automatic vec(input logic rst, input logic [1:0] dc, input logic [31:0] da, input logic [63:0] dd,
                     input logic [1:0] ic, input logic [31:0] ia, input logic [3:0] rsp, input logic [3:0] rt,
                     input logic [1:0] ecmd, input logic [31:0] eaddr, input logic [63:0] edata, input logic edreq,
                     input logic [3:0] edresp, input logic [3:0] eiresp, input logic [3:0] edtag,
                     input logic [3:0] eitag, input logic [3:0] eout, input logic eorph);
    exp_t e;
    @(posedge clock);
    #1;
    reset = rst;
    Dproc2mem_command = dc; Dproc2mem_addr = da; Dproc2mem_data = dd;
    Iproc2mem_command = ic; Iproc2mem_addr = ia;
    mem2proc_response = rsp; mem2proc_tag = rt;
    mem2proc_data = {ia ^ 32'hC0DE_0000, da};
    e = '{cmd: ecmd, addr: eaddr, data: edata, dout: {ia ^ 32'hC0DE_0000, da}, dreq: edreq,
          dresp: edresp, iresp: eiresp, dtag: edtag, itag: eitag, outst: eout, orph: eorph};
    q.push_back(e);
  endtask

  always @(negedge clock) begin
    exp_t e, a;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = '{cmd: proc2mem_command, addr: proc2mem_addr, data: proc2mem_data, dout: mem2proc_data_out,
            dreq: d_request, dresp: Dmem2proc_response, iresp: Imem2proc_response, dtag: Dmem2proc_tag,
            itag: Imem2proc_tag, outst: outstanding, orph: orphan_err};
      vec_no++;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL vec%0d: got cmd=%0d addr=%h data=%h dout=%h dreq=%b dresp=%0d iresp=%0d dtag=%0d itag=%0d outst=%0d orph=%b; want cmd=%0d addr=%h data=%h dout=%h dreq=%b dresp=%0d iresp=%0d dtag=%0d itag=%0d outst=%0d orph=%b",
                 vec_no, a.cmd, a.addr, a.data, a.dout, a.dreq, a.dresp, a.iresp, a.dtag, a.itag, a.outst, a.orph,
                 e.cmd, e.addr, e.data, e.dout, e.dreq, e.dresp, e.iresp, e.dtag, e.itag, e.outst, e.orph);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clock);
    //   rst dc  daddr    ddata ic  iaddr    rsp rt  | cmd addr     data dreq dr ir dt it out orph
    vec(1, L, 32'h100, DD, L, 32'h400, 3, 3,   N, 32'h0,   '0, 0, 0, 0, 0, 0, 0, 0);
    vec(0, L, 32'h100, DD, N, 32'h0,   3, 0,   L, 32'h100, '0, 1, 3, 0, 0, 0, 0, 0);
    vec(0, N, 32'h0,   '0, N, 32'h0,   0, 0,   N, 32'h0,   '0, 0, 0, 0, 0, 0, 1, 0);
    vec(0, N, 32'h0,   '0, N, 32'h0,   0, 3,   N, 32'h0,   '0, 0, 0, 0, 3, 0, 1, 0);
    vec(0, N, 32'h0,   '0, N, 32'h0,   0, 0,   N, 32'h0,   '0, 0, 0, 0, 0, 0, 0, 0);
    vec(0, S, 32'h200, DD, N, 32'h0,   5, 0,   S, 32'h200, DD, 1, 5, 0, 0, 0, 0, 0);
    vec(0, N, 32'h0,   '0, N, 32'h0,   0, 5,   N, 32'h0,   '0, 0, 0, 0, 0, 0, 0, 0);
    vec(0, N, 32'h0,   '0, N, 32'h0,   0, 0,   N, 32'h0,   '0, 0, 0, 0, 0, 0, 0, 1);
    vec(0, L, 32'h300, DD, L, 32'h400, 0, 0,   L, 32'h300, '0, 1, 0, 0, 0, 0, 0, 1);
    vec(0, L, 32'h300, DD, L, 32'h400, 0, 0,   L, 32'h300, '0, 1, 0, 0, 0, 0, 0, 1);
    vec(0, L, 32'h300, DD, L, 32'h400, 0, 0,   L, 32'h300, '0, 1, 0, 0, 0, 0, 0, 1);
    vec(0, L, 32'h300, DD, L, 32'h400, 0, 0,   L, 32'h300, '0, 1, 0, 0, 0, 0, 0, 1);
    vec(0, L, 32'h300, DD, L, 32'h400, 7, 0,   L, 32'h400, '0, 0, 0, 7, 0, 0, 0, 1);
    vec(0, L, 32'h300, DD, L, 32'h400, 7, 7,   L, 32'h300, '0, 1, 7, 0, 0, 7, 1, 1);
    vec(0, N, 32'h0,   '0, N, 32'h0,   0, 7,   N, 32'h0,   '0, 0, 0, 0, 7, 0, 1, 1);
    vec(0, L, 32'h500, DD, N, 32'h0,   0, 0,   L, 32'h500, '0, 1, 0, 0, 0, 0, 0, 1);
    vec(0, N, 32'h0,   '0, N, 32'h0,   0, 0,   N, 32'h0,   '0, 0, 0, 0, 0, 0, 0, 1);
    vec(0, N, 32'h0,   '0, L, 32'h600, 9, 0,   L, 32'h600, '0, 0, 0, 9, 0, 0, 0, 1);
    vec(0, L, 32'h700, DD, N, 32'h0,   2, 0,   L, 32'h700, '0, 1, 2, 0, 0, 0, 1, 1);
    vec(1, L, 32'h700, DD, N, 32'h0,   4, 9,   N, 32'h0,   '0, 0, 0, 0, 0, 0, 2, 1);
    vec(0, N, 32'h0,   '0, N, 32'h0,   0, 9,   N, 32'h0,   '0, 0, 0, 0, 0, 0, 0, 0);
    vec(0, N, 32'h0,   '0, N, 32'h0,   0, 0,   N, 32'h0,   '0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clock);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
